// File: rtl/input_circuit_ctrl.sv
// Input-circuit sequencer for the FFT front end.
// Steers samples into an 8-deep shift chain (Q7 newest .. Q0 oldest), parks up
// to three samples in a side buffer while a finished group waits for the
// butterfly stage, and selects the real/imag swap applied at the input.
module input_circuit_ctrl #(
  parameter int SEG_DEPTH = 8,
  parameter int FRAME_LEN = 64,
  parameter int BUF_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_swap,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       grp_ready,
  output logic       grp_valid,
  output logic [2:0] grp_idx,
  output logic       frame_last,
  output logic       mode,
  output logic       hold_all_seg,
  output logic       hold_buf_0,
  output logic       hold_buf_1,
  output logic       hold_buf_2,
  output logic       in_ctrl_buf_0,
  output logic       in_ctrl_buf_1,
  output logic       in_ctrl_buf_2,
  output logic       pos_hold_ctrl,
  output logic [1:0] buf_cnt
);

  localparam int FW = $clog2(SEG_DEPTH + 1);
  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [FW-1:0] CHAIN_FULL = FW'(SEG_DEPTH);
  localparam logic [1:0]    BUF_FULL   = 2'(BUF_DEPTH);
  localparam logic [SW-1:0] SCNT_LAST  = SW'(FRAME_LEN - 1);

  logic [FW-1:0] fcnt;
  logic [1:0]    bcnt;
  logic [SW-1:0] scnt;
  logic [2:0]    gcnt;
  logic          mode_r;

  logic          buf_nz;
  logic          avail;
  logic          fire;
  logic          shift;
  logic          grp_hs;
  logic [2:0]    hold_v;
  logic [2:0]    ctrl_v;

  // Handshake and chain-advance decode; in_ready never looks at in_valid.
  always_comb begin
    buf_nz    = (bcnt != 2'd0);
    grp_valid = (fcnt == CHAIN_FULL);
    avail     = ~grp_valid | grp_ready;
    in_ready  = (bcnt != BUF_FULL) | avail;
    fire      = in_valid & in_ready;
    shift     = avail & (buf_nz | fire);
    grp_hs    = grp_valid & grp_ready;
  end

  // Side-buffer steering: park on a stalled chain, drain oldest-first otherwise.
  always_comb begin
    hold_v = 3'b111;
    ctrl_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (fire && !shift) begin
        if (int'(bcnt) == k) begin
          hold_v[k] = 1'b0;
          ctrl_v[k] = 1'b1;
        end
      end else if (shift && buf_nz) begin
        if (k + 1 < int'(bcnt)) begin
          hold_v[k] = 1'b0;
          ctrl_v[k] = 1'b0;
        end else if ((k + 1 == int'(bcnt)) && fire) begin
          hold_v[k] = 1'b0;
          ctrl_v[k] = 1'b1;
        end
      end
    end
  end

  // Output mapping; the swap for a frame is taken from cfg_swap on its first sample.
  always_comb begin
    hold_all_seg  = ~shift;
    pos_hold_ctrl = buf_nz;
    buf_cnt       = bcnt;
    grp_idx       = gcnt;
    frame_last    = grp_valid & (gcnt == 3'd7);
    mode          = (scnt == '0) ? cfg_swap : mode_r;
    hold_buf_0    = hold_v[0];
    hold_buf_1    = hold_v[1];
    hold_buf_2    = hold_v[2];
    in_ctrl_buf_0 = ctrl_v[0];
    in_ctrl_buf_1 = ctrl_v[1];
    in_ctrl_buf_2 = ctrl_v[2];
  end

  // Chain occupancy: a delivered group empties the chain, a shift adds one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
    end else if (grp_hs) begin
      fcnt <= shift ? FW'(1) : '0;
    end else if (shift) begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // Side-buffer occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
    end else if (fire && !shift) begin
      bcnt <= bcnt + 2'd1;
    end else if (shift && buf_nz && !fire) begin
      bcnt <= bcnt - 2'd1;
    end
  end

  // Group number within the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt <= '0;
    end else if (grp_hs) begin
      gcnt <= gcnt + 3'd1;
    end
  end

  // Frame sample position and the swap latched for the rest of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt   <= '0;
      mode_r <= 1'b0;
    end else if (fire) begin
      if (scnt == '0) begin
        mode_r <= mode;
      end
      scnt <= (scnt == SCNT_LAST) ? '0 : scnt + SW'(1);
    end
  end

endmodule

// File: doc/input_circuit_ctrl.md
Name: input_circuit_ctrl

Overview:
- Sequencer for the FFT input-circuit datapath: 32-bit sample shift chain (lead buffer + 7 segments, Q7..Q0), a 3-entry side buffer (buf_0..buf_2), a head mux and an input real/imag swap.
- Accepts samples on a valid/ready handshake and shifts them into the chain.
- Presents each full 8-sample group to the downstream butterfly stage on a valid/ready handshake.
- While the chain is held for an unaccepted group, parks up to 3 incoming samples in the side buffer, then drains them in order.

Parameters:
SEG_DEPTH, 8, samples per group (chain length); fixed at 8 for this datapath
FRAME_LEN, 64, samples per FFT frame; must be a multiple of SEG_DEPTH
BUF_DEPTH, 3, side-buffer entries; fixed at 3 for this datapath

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
cfg_swap  in  1  requested real/imag interchange, sampled at frame start
in_valid  in  1  upstream sample valid (data goes straight to datapath D)
in_ready  out  1  controller can accept a sample this cycle
grp_ready  in  1  downstream accepts current group
grp_valid  out  1  chain holds a full group on Q0..Q7
grp_idx  out  3  group number within frame, 0..7
frame_last  out  1  grp_valid and grp_idx==7
mode  out  1  datapath swap control
hold_all_seg  out  1  freeze lead buffer and segments
hold_buf_0, hold_buf_1, hold_buf_2  out  1 each  freeze side-buffer entry k
in_ctrl_buf_0, in_ctrl_buf_1, in_ctrl_buf_2  out  1 each  entry k: 1 = load input, 0 = load entry k+1 (entry 2 loads 0)
pos_hold_ctrl  out  1  head mux: 0 = direct input, 1 = buf_0
buf_cnt  out  2  side-buffer occupancy, 0..3

Behaviour:
- State: fcnt (0..8, valid samples in chain), bcnt (0..3), scnt (0..FRAME_LEN-1, accepted samples), gcnt (0..7), mode_r.
- Reset (rst low, asynchronous): all state 0.
- Outputs after reset: in_ready=1, grp_valid=0, hold_all_seg=1, all hold_buf_k=1, pos_hold_ctrl=0, mode=cfg_swap.
- Reset mid-operation discards chain, buffer and frame position; there is no partial-group output.
- Definitions:
  - fire = in_valid & in_ready
  - avail = (fcnt<8) | grp_ready
  - shift = avail & (bcnt>0 | fire)
- in_ready = (bcnt<3) | shift. Combinational from state and grp_ready; never from in_valid.
- hold_all_seg = ~shift. pos_hold_ctrl = (bcnt>0). Sample order is always buffer entries oldest-first, then direct input.
- Side-buffer control, per cycle. Entries not named below hold (hold_buf_k=1).
  - fire & ~shift: entry bcnt loads input (hold=0, in_ctrl=1); bcnt+1.
  - shift & bcnt>0: entries 0..bcnt-2 load from above (hold=0, in_ctrl=0).
    - If fire: entry bcnt-1 loads input (hold=0, in_ctrl=1); bcnt unchanged.
    - If no fire: entry bcnt-1 holds (stale, don't-care); bcnt-1.
  - shift & bcnt==0: all entries hold; the direct path is used.
- Chain count: grp_valid = (fcnt==8).
  - Group handshake (grp_valid & grp_ready) at the same edge as shift: fcnt becomes 1.
  - Group handshake without shift: fcnt becomes 0.
  - Otherwise fcnt+shift.
  - Downstream samples Q0..Q7 at the handshake edge; they are stable for the whole cycle.
- Group counter: gcnt increments on each group handshake and wraps 7->0. grp_idx = gcnt.
- Mode:
  - mode = (scnt==0) ? cfg_swap : mode_r.
  - mode_r <= mode on fire with scnt==0.
  - scnt increments on fire and wraps FRAME_LEN-1 -> 0.
  - cfg_swap changes mid-frame have no effect until the next frame's first sample.
  - Mode is applied at input time, so a buffered sample keeps the swap it was captured with.
- Latency: a sample accepted with empty buffer and non-full chain appears on Q7 one cycle later. The 8th sample of a group makes grp_valid=1 the next cycle.
- Full: bcnt==3 and ~avail gives in_ready=0.
- Simultaneous fire, group handshake and bcnt==3: buffer shifts, entry 2 loads input, chain takes buf_0, fcnt becomes 1, bcnt stays 3.
- Throughput: one sample per cycle sustained when grp_ready is held high.

Test Plan:
- Reset, grp_ready=1, 64 back-to-back samples 0..63 -> grp_valid on 8 cycles (one per 8 samples), Q0..Q7 = {8g..8g+7}, grp_idx 0..7, frame_last on the last group only, buf_cnt stays 0.
- Stall: grp_ready=0 after group 0 is full, feed 5 samples -> 3 accepted into buf (buf_cnt=3), in_ready=0. Raise grp_ready for 1 cycle -> buf_0 shifts in and in_ready=1 the same cycle. Group 1 order is exact: 8,9,10,11,... with no loss or duplicates.
- Full-buffer simultaneous event: bcnt=3, in_valid=1, grp_ready pulse -> bcnt stays 3, the new sample lands in entry 2, fcnt=1.
- cfg_swap toggled at sample 20 of a frame -> mode constant through sample 63, new value from sample 64 onward.
- Assert rst low at sample 37 with buf_cnt=2 -> next cycle all counters 0, grp_valid=0, hold_all_seg=1, mode=cfg_swap. The next sample is treated as sample 0 of group 0.
- Random in_valid/grp_ready (50%, 10k cycles) -> scoreboard confirms in-order delivery. in_ready never high when bcnt==3 and avail=0. hold_buf/in_ctrl outputs match the rules every cycle.
